reg_bank_wb: RTL and testbench

- General-purpose register bank at the consuming end of the write-data selection path: 32 x 32-bit registers, one write port fed by the WD mux output, and two combinational read ports for the datapath.
- Adds write-through bypass on the read ports.
- Adds a sequential debug dump engine that streams all registers out, one per cycle, under a start/busy/valid handshake for the testbench and debug monitor.

---
 rtl/reg_bank_wb.sv | 92 +++++++++
 tb/tb_reg_bank_wb.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_wb.sv
// General-purpose register bank with a write-through bypass on both read ports
// and a debug engine that streams every register out, one per cycle.
module reg_bank_wb #(
  parameter int          NREGS    = 32,
  parameter int          SP_INDEX = 29,
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter bit          BYPASS   = 1'b1,
  localparam int         AW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          reg_write,
  input  logic [AW-1:0] write_reg,
  input  logic [31:0]   write_data,
  input  logic [AW-1:0] read_reg1,
  input  logic [AW-1:0] read_reg2,
  output logic [31:0]   read_data1,
  output logic [31:0]   read_data2,
  input  logic          dump_start,
  output logic          dump_busy,
  output logic          dump_valid,
  output logic [AW-1:0] dump_addr,
  output logic [31:0]   dump_data,
  output logic          dump_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  logic [31:0]   regs [NREGS];
  state_t        state, state_next;
  logic [AW-1:0] cnt;
  logic [AW-1:0] last_addr;
  logic [31:0]   last_data;

  // Register 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_RESET : 32'd0;
      end
    end else if (reg_write && (write_reg != '0)) begin
      regs[write_reg] <= write_data;
    end
  end

  always_comb begin
    read_data1 = regs[read_reg1];
    if (BYPASS && reg_write && (write_reg == read_reg1)) read_data1 = write_data;
    if (read_reg1 == '0) read_data1 = 32'd0;

    read_data2 = regs[read_reg2];
    if (BYPASS && reg_write && (write_reg == read_reg2)) read_data2 = write_data;
    if (read_reg2 == '0) read_data2 = 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dump_start) state_next = RUN;
      RUN:     if (cnt == AW'(NREGS - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The held copies let dump_addr/dump_data keep the last emitted entry outside RUN.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt       <= '0;
      last_addr <= '0;
      last_data <= 32'd0;
    end else if (state == RUN) begin
      cnt       <= cnt + 1'b1;
      last_addr <= cnt;
      last_data <= regs[cnt];
    end else begin
      cnt <= '0;
    end
  end

  assign dump_busy  = (state == RUN);
  assign dump_valid = (state == RUN);
  assign dump_done  = (state == DONE);
  assign dump_addr  = dump_valid ? cnt : last_addr;
  assign dump_data  = dump_valid ? regs[cnt] : last_data;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Scoreboard bench for reg_bank_wb: read ports checked directly, dump stream
// checked by a monitor that pops expected entries from a queue.
module tb_reg_bank_wb;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } dump_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1, read_reg2;
  logic [31:0] read_data1, read_data2;
  logic        dump_start;
  logic        dump_busy, dump_valid, dump_done;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;

  logic [31:0] nb_read_data1, nb_read_data2;
  logic        nb_dump_busy, nb_dump_valid, nb_dump_done;
  logic [4:0]  nb_dump_addr;
  logic [31:0] nb_dump_data;

  int          tests = 0;
  int          fails = 0;
  int          doneCount = 0;
  dump_t       expQ[$];
  logic [31:0] model [32];

  reg_bank_wb #(.BYPASS(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2), .dump_start(dump_start),
    .dump_busy(dump_busy), .dump_valid(dump_valid), .dump_addr(dump_addr),
    .dump_data(dump_data), .dump_done(dump_done)
  );

  reg_bank_wb #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(nb_read_data1), .read_data2(nb_read_data2), .dump_start(dump_start),
    .dump_busy(nb_dump_busy), .dump_valid(nb_dump_valid), .dump_addr(nb_dump_addr),
    .dump_data(nb_dump_data), .dump_done(nb_dump_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drives one cycle of port inputs at the falling edge; comb reads settle 1 time unit later.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra1, input logic [4:0] ra2);
    @(negedge clk);
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
    read_reg1  = ra1;
    read_reg2  = ra2;
    if (we && wa != 5'd0) model[wa] = wd;
    #1;
  endtask

  // Monitor: every valid dump beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (dump_done) doneCount++;
    if (dump_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("dump_unexpected", {27'd0, dump_addr}, 32'hFFFF_FFFF);
      end else begin
        dump_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("dump_addr[%0d]", e.addr), {27'd0, dump_addr}, {27'd0, e.addr});
        checkOutput($sformatf("dump_data[%0d]", e.addr), dump_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pushDump(input int ovIdx, input logic [31:0] ovData);
    dump_t e;
    for (int i = 0; i < 32; i++) begin
      e.addr = 5'(i);
      e.data = (i == ovIdx) ? ovData : model[i];
      expQ.push_back(e);
    end
  endtask

  initial begin
    int nvalid;
    int cyc;
    int doneBefore;

    reset_n = 1'b0; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = '0; read_reg2 = '0; dump_start = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1'b0, 5'd0, 32'd0, 5'd29, 5'd5);
    checkOutput("reset_sp", read_data1, 32'd227);
    checkOutput("reset_r5", read_data2, 32'd0);
    checkOutput("reset_busy", {31'd0, dump_busy}, 32'd0);
    checkOutput("reset_valid", {31'd0, dump_valid}, 32'd0);
    checkOutput("reset_done", {31'd0, dump_done}, 32'd0);

    applyStimulus(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
    checkOutput("write_r8_p1", read_data1, 32'hDEAD_BEEF);
    checkOutput("write_r8_p2", read_data2, 32'hDEAD_BEEF);

    applyStimulus(1'b1, 5'd0, 32'h1234_5678, 5'd0, 5'd0);
    checkOutput("r0_bypass", read_data1, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkOutput("r0_stored", read_data1, 32'd0);

    applyStimulus(1'b1, 5'd3, 32'hA5A5_A5A5, 5'd0, 5'd3);
    checkOutput("bypass_on", read_data2, 32'hA5A5_A5A5);
    checkOutput("bypass_off", nb_read_data2, 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd3);
    checkOutput("bypass_off_stored", nb_read_data2, 32'hA5A5_A5A5);

    for (int n = 1; n < 32; n++) applyStimulus(1'b1, 5'(n), 32'(n + 100), 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd31, 5'd29);
    checkOutput("fill_r31", read_data1, 32'd131);
    checkOutput("fill_r29", read_data2, 32'd129);

    // Full dump of n+100 pattern
    pushDump(-1, 32'd0);
    doneBefore = doneCount;
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    checkOutput("dump_latency", {31'd0, dump_valid}, 32'd1);
    nvalid = 0; cyc = 0;
    while (dump_valid && cyc < 100) begin
      nvalid++;
      @(negedge clk);
      cyc++;
    end
    checkOutput("dump_len", nvalid, 32);
    checkOutput("dump_done_pulse", {31'd0, dump_done}, 32'd1);
    checkOutput("done_busy", {31'd0, dump_busy}, 32'd0);
    checkOutput("hold_addr", {27'd0, dump_addr}, 32'd31);
    checkOutput("hold_data", dump_data, 32'd131);
    @(negedge clk);
    checkOutput("done_one_cycle", {31'd0, dump_done}, 32'd0);
    checkOutput("done_count1", doneCount - doneBefore, 32'd1);
    checkOutput("queue_empty1", expQ.size(), 32'd0);

    // Writes during a dump plus an ignored restart
    pushDump(20, 32'hFFFF_0000);
    doneBefore = doneCount;
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    nvalid = 0; cyc = 0;
    while (dump_valid && cyc < 100) begin
      reg_write  = (dump_addr == 5'd10) || (dump_addr == 5'd11);
      write_reg  = (dump_addr == 5'd10) ? 5'd20 : 5'd5;
      write_data = (dump_addr == 5'd10) ? 32'hFFFF_0000 : 32'h5555_0005;
      dump_start = (dump_addr == 5'd12);
      nvalid++;
      @(negedge clk);
      cyc++;
    end
    reg_write = 1'b0;
    model[20] = 32'hFFFF_0000;
    model[5]  = 32'h5555_0005;
    checkOutput("dump2_len", nvalid, 32);
    checkOutput("dump2_done", {31'd0, dump_done}, 32'd1);
    dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    checkOutput("start_in_done_busy", {31'd0, dump_busy}, 32'd0);
    checkOutput("start_in_done_valid", {31'd0, dump_valid}, 32'd0);
    checkOutput("done_count2", doneCount - doneBefore, 32'd1);
    checkOutput("queue_empty2", expQ.size(), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 5'd5, 5'd20);
    checkOutput("mid_write_r5", read_data1, 32'h5555_0005);
    checkOutput("mid_write_r20", read_data2, 32'hFFFF_0000);

    // Reset aborts a dump part-way
    pushDump(-1, 32'd0);
    @(negedge clk); dump_start = 1'b1;
    @(negedge clk); dump_start = 1'b0;
    cyc = 0;
    while (dump_valid && dump_addr != 5'd15 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_reach", {27'd0, dump_addr}, 32'd15);
    doneBefore = doneCount;
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", {31'd0, dump_busy}, 32'd0);
    checkOutput("abort_valid", {31'd0, dump_valid}, 32'd0);
    checkOutput("abort_done", {31'd0, dump_done}, 32'd0);
    checkOutput("abort_addr", {27'd0, dump_addr}, 32'd0);
    checkOutput("abort_data", dump_data, 32'd0);
    expQ.delete();
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", doneCount - doneBefore, 32'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 5'(i), 5'd0);
      checkOutput($sformatf("post_reset_r%0d", i), read_data1, (i == 29) ? 32'd227 : 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
